// File: rtl/bit8_div4_pkg.sv
// bit8_div4_pkg: shared widths, step-counter width and FSM state encoding for the byte-by-nibble divider
package bit8_div4_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/bit8_divide_bit4_div_step.sv
// div_step: one combinational restoring shift-subtract step on a 5-bit partial remainder
module div_step
  import bit8_div4_pkg::*;
(
  input  logic [DIVISOR_W:0]   p_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   p_o,
  output logic                 q_o
);
  logic [DIVISOR_W:0] p_sh;
  // shift in the next dividend bit, subtract when the divisor fits
  always_comb begin
    p_sh = {p_i[DIVISOR_W-1:0], bit_i};
    q_o  = p_sh >= {1'b0, divisor_i};
    p_o  = q_o ? p_sh - {1'b0, divisor_i} : p_sh;
  end
endmodule

// File: rtl/bit8_divide_bit4.sv
// bit8_divide_bit4: sequential 8/4 restoring divider, one quotient bit per clock; DIV_ZERO_DETECT_EN adds div_zero fast path
module bit8_divide_bit4
  import bit8_div4_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV_ZERO_DETECT_EN
  , output logic                div_zero
`endif
);
  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d, quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d, rem_q, rem_d;
  logic [DIVISOR_W:0]    p_q, p_d, p_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  q_bit, accept, zero, last;
`ifdef DIV_ZERO_DETECT_EN
  logic                  dz_q, dz_d;
  assign zero     = divisor == '0;
  assign div_zero = dz_q;
`else
  assign zero = 1'b0;
`endif
  assign accept    = state_q == IDLE && start;
  assign last      = cnt_q == '1;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  div_step u_step (
    .p_i       (p_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .p_o       (p_nxt),
    .q_o       (q_bit)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next state: divisor zero with detection skips RUN; DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? (zero ? DONE : RUN) : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  // datapath next state: dividend register shifts out dividend bits and shifts in quotient bits
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d  = accept ? zero : dz_q;
`endif
    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      p_d   = '0;
      cnt_d = '0;
      quo_d = zero ? '1 : quo_q;
      rem_d = zero ? dividend[DIVISOR_W-1:0] : rem_q;
    end else if (state_q == RUN) begin
      dvd_d = {dvd_q[DIVIDEND_W-2:0], q_bit};
      p_d   = p_nxt;
      cnt_d = cnt_q + CNT_W'(1);
      quo_d = last ? {dvd_q[DIVIDEND_W-2:0], q_bit} : quo_q;
      rem_d = last ? p_nxt[DIVISOR_W-1:0] : rem_q;
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q  <= dz_d;
`endif
    end
endmodule

// File: tb/tb_bit8_divide_bit4.sv
// tb_bit8_divide_bit4: randomized and directed checks of the divider against an arithmetic reference
module tb_bit8_divide_bit4;
  logic       clk = 0, rst = 1, start = 0;
  logic [7:0] dividend = 0, quotient;
  logic [3:0] divisor = 0, remainder;
  logic       busy, done;
  int         errors = 0, checks = 0;
`ifdef DIV_ZERO_DETECT_EN
  logic       div_zero;
  localparam bit DZ = 1;
`else
  localparam bit DZ = 0;
`endif
  bit8_divide_bit4 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
    , .div_zero (div_zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // called at a negedge while idle; returns at the negedge after the done cycle
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input string tag);
    logic [7:0] eq;
    logic [3:0] er;
    int         lat, exp_lat;
    eq      = b == 0 ? 8'hFF : a / b;
    er      = b == 0 ? a[3:0] : 4'(a % b);
    exp_lat = (DZ && b == 0) ? 0 : 8;
    start = 1; dividend = a; divisor = b;
    @(negedge clk);
    start = 0; dividend = 8'($urandom); divisor = 4'($urandom);
    check({tag, "_busy"}, busy, !(DZ && b == 0));
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    if (b != 0) begin
      check({tag, "_ident"}, quotient * b + remainder, a);
      check({tag, "_rlt"}, remainder < b, 1);
    end
`ifdef DIV_ZERO_DETECT_EN
    check({tag, "_dz"}, div_zero, b == 0);
`endif
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, {quotient, remainder}, {eq, er});
  endtask
  initial begin
    int ndone;
    logic [7:0] cap;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst = 0;
    @(negedge clk);
    run_div(8'hFF, 4'h1, "d1");
    run_div(8'hFF, 4'h4, "d2");
    run_div(8'hFD, 4'h6, "d3");
    run_div(8'h3F, 4'h8, "b1");
    run_div(8'hA5, 4'h2, "b2");
    run_div(8'h67, 4'h3, "b3");
    run_div(8'h5A, 4'h0, "z0");
    repeat (30) run_div(8'($urandom), 4'($urandom), "rnd");
    // start pulses during busy and in the done cycle must be ignored
    start = 1; dividend = 8'hC8; divisor = 4'h7;
    @(negedge clk);
    start = 0;
    ndone = 0; cap = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 3) || (done && ndone == 0);
      dividend = 8'h11; divisor = 4'h2;
      if (done) begin ndone++; cap = quotient; end
      @(negedge clk);
    end
    start = 0;
    check("ign_ndone", ndone, 1);
    check("ign_q", cap, 8'd28);
    check("ign_r", remainder, 4'd4);
    check("ign_idle", busy, 0);
    // reset in the middle of a division aborts it
    start = 1; dividend = 8'hFF; divisor = 4'hF;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    @(negedge clk);
    rst = 0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      ndone += done;
    end
    check("arst_nodone", ndone, 0);
    run_div(8'hFF, 4'hF, "post");
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run_div(8'(a), 4'(b), "sw");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
